// File: rtl/bpsk_pkg.sv
// Shared BPSK constants and FSM state type; the modulator and data generator
// use the same bit period and sync word.
package bpsk_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    localparam int         BPSK_BIT_PERIOD = 1200;
    localparam logic [7:0] BPSK_SYNC_WORD  = 8'hB2;

endpackage

// File: rtl/bpsk_bit_sampler.sv
// Bit-timing recovery: 2FF synchroniser, transition detector and a phase
// counter that re-zeroes on every transition and strobes at mid-bit.
module bpsk_bit_sampler
    import bpsk_pkg::*;
#(
    parameter int BIT_PERIOD = BPSK_BIT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    output logic bit_strobe,
    output logic sample
);

    localparam int HALF = BIT_PERIOD / 2;
    localparam int PW   = $clog2(BIT_PERIOD);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          edge_det;

    // Synchroniser, transition detect and phase counter next-state
    always_comb begin
        s1_d     = bit_in;
        s2_d     = s1_q;
        prev_d   = s2_q;
        edge_det = s2_q ^ prev_q;
        if (edge_det)
            phase_d = '0;
        else if (phase_q == PW'(BIT_PERIOD - 1))
            phase_d = '0;
        else
            phase_d = phase_q + PW'(1);
        // A transition landing on the sample point wins: the bit is re-timed
        bit_strobe = (phase_q == PW'(HALF - 1)) && !edge_det;
        sample     = s2_q;
    end

    // Sampler state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/bpsk_frame_sync.sv
// BPSK frame synchroniser: recovers bit timing, hunts for the sync word and
// deserialises PAYLOAD_BYTES bytes MSB-first after each sync.
// Optional feature macro: INVERT_DETECT_EN (also lock on the inverted sync
// word and invert the payload, resolving the 180-degree phase ambiguity).
module bpsk_frame_sync
    import bpsk_pkg::*;
#(
    parameter int         BIT_PERIOD    = BPSK_BIT_PERIOD,
    parameter logic [7:0] SYNC_WORD     = BPSK_SYNC_WORD,
    parameter int         PAYLOAD_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    output logic       bit_strobe,
    output logic       locked,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       polarity
);

    localparam int BCW = $clog2(PAYLOAD_BYTES + 1);

    logic           sample;
    state_e         state_q, state_d;
    logic [6:0]     shreg_q, shreg_d;      // last 7 hunt samples; 8th is the live one
    logic [3:0]     fill_q, fill_d;
    logic [6:0]     byte_sr_q, byte_sr_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           byte_valid_q, byte_valid_d;
    logic           frame_done_q, frame_done_d;
    logic [7:0]     cand;
    logic           data_bit;
`ifdef INVERT_DETECT_EN
    logic           pol_q, pol_d;
`endif

    bpsk_bit_sampler #(.BIT_PERIOD(BIT_PERIOD)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_strobe (bit_strobe),
        .sample     (sample)
    );

    // Hunt / payload FSM and deserialiser, advanced only on sample strobes
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        fill_d       = fill_q;
        byte_sr_d    = byte_sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        cand         = {shreg_q, sample};
`ifdef INVERT_DETECT_EN
        pol_d        = pol_q;
        data_bit     = sample ^ pol_q;
`else
        data_bit     = sample;
`endif
        if (bit_strobe) begin
            case (state_q)
                HUNT: begin
                    shreg_d = cand[6:0];
                    if (fill_q != 4'd8)
                        fill_d = fill_q + 4'd1;
                    if (fill_q >= 4'd7 && cand == SYNC_WORD) begin
                        state_d    = PAYLOAD;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
`ifdef INVERT_DETECT_EN
                        pol_d      = 1'b0;
`endif
                    end
`ifdef INVERT_DETECT_EN
                    else if (fill_q >= 4'd7 && cand == ~SYNC_WORD) begin
                        state_d    = PAYLOAD;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        pol_d      = 1'b1;
                    end
`endif
                end
                PAYLOAD: begin
                    byte_sr_d = {byte_sr_q[5:0], data_bit};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_d   = {byte_sr_q, data_bit};
                        byte_valid_d = 1'b1;
                        byte_cnt_d   = byte_cnt_q + 1'b1;
                        // Last byte: back to hunting with an empty window
                        if (byte_cnt_q == BCW'(PAYLOAD_BYTES - 1)) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                            shreg_d      = '0;
                            fill_d       = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            shreg_q      <= '0;
            fill_q       <= '0;
            byte_sr_q    <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            fill_q       <= fill_d;
            byte_sr_q    <= byte_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef INVERT_DETECT_EN
    // Detected polarity, held until the next sync or reset
    always_ff @(posedge clk) begin
        if (rst) pol_q <= 1'b0;
        else     pol_q <= pol_d;
    end
    assign polarity = pol_q;
`else
    assign polarity = 1'b0;
`endif

    assign locked     = (state_q == PAYLOAD);
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_done = frame_done_q;

endmodule
